// File: rtl/snac_db15_reader.sv
// SNAC DB15 serial reader: scans a 165-style shift chain and accepts a frame only when two consecutive frames agree.
// Latency: outputs follow a button change within 1-2 frames; free-running scan, no backpressure.
module snac_db15_reader #(
  parameter int CLK_DIV   = 24,
  parameter int NBITS     = 24,
  parameter int GAP_TICKS = 64
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        enable,
  input  logic        JOY_DATA,
  output logic        JOY_CLK,
  output logic        JOY_LOAD,
  output logic [15:0] joystick1,
  output logic [15:0] joystick2,
  output logic        frame_stb
);
  localparam int HALF  = NBITS / 2;
  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int IDX_W = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam int CNT_W = $clog2(GAP_TICKS + 2);

  typedef enum logic [2:0] {
    S_GAP,
    S_LOAD,
    S_SHA,
    S_SHB,
    S_DONE
  } state_t;

  state_t           state, state_nxt;
  logic [DIV_W-1:0] div;
  logic             tick;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [IDX_W-1:0] idx, idx_nxt;
  logic [NBITS-1:0] sh, prev;
  logic             data_s1, data_s2;
  logic             sample;

  assign tick = (div == DIV_W'(CLK_DIV - 1));

  // Divider freezes during the single DONE cycle so every frame is one cycle longer than a whole number of ticks.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      div <= '0;
    end else if (state != S_DONE) begin
      div <= tick ? '0 : div + DIV_W'(1);
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      data_s1 <= 1'b1;
      data_s2 <= 1'b1;
    end else begin
      data_s1 <= JOY_DATA;
      data_s2 <= data_s1;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    sample    = 1'b0;
    case (state)
      S_GAP: begin
        if (tick) begin
          if (cnt >= CNT_W'(GAP_TICKS - 1)) begin
            if (enable) begin
              state_nxt = S_LOAD;
              cnt_nxt   = '0;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      S_LOAD: begin
        if (tick) begin
          if (cnt == CNT_W'(1)) begin
            state_nxt = S_SHA;
            cnt_nxt   = '0;
            idx_nxt   = '0;
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end
      S_SHA: begin
        if (tick) state_nxt = S_SHB;
      end
      S_SHB: begin
        // Capture just before the rising edge: the synchronised data has had the whole bit period to settle.
        if (tick) begin
          sample = 1'b1;
          if (idx == IDX_W'(NBITS - 1)) begin
            state_nxt = S_DONE;
          end else begin
            idx_nxt   = idx + IDX_W'(1);
            state_nxt = S_SHA;
          end
        end
      end
      S_DONE: begin
        state_nxt = S_GAP;
        cnt_nxt   = '0;
      end
      default: state_nxt = S_GAP;
    endcase
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state     <= S_GAP;
      cnt       <= '0;
      idx       <= '0;
      sh        <= '0;
      prev      <= '0;
      joystick1 <= '0;
      joystick2 <= '0;
      JOY_CLK   <= 1'b1;
      JOY_LOAD  <= 1'b1;
      frame_stb <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      idx       <= idx_nxt;
      JOY_CLK   <= (state_nxt != S_SHB);
      JOY_LOAD  <= (state_nxt != S_LOAD);
      frame_stb <= (state_nxt == S_DONE);
      if (sample) sh[idx] <= ~data_s2;
      if (state == S_DONE) begin
        if (sh == prev) begin
          joystick1 <= 16'(sh[HALF-1:0]);
          joystick2 <= 16'(sh[NBITS-1:HALF]);
        end
        prev <= sh;
      end else if (state == S_GAP && !enable) begin
        joystick1 <= '0;
        joystick2 <= '0;
        prev      <= '0;
      end
    end
  end
endmodule

// File: tb/tb_snac_db15_reader.sv
// Bench for snac_db15_reader: behavioural 165 chain, frame-level debounce model, vector table plus random frames.
module tb_snac_db15_reader;
  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        joy_data, joy_clk, joy_load, stb;
  logic [15:0] j1, j2;
  logic        d_data = 1'b1;
  logic        d_clk, d_load, d_stb;
  logic [15:0] d_j1, d_j2;

  logic [23:0] chain_word = 24'hFFFFFF;
  logic [23:0] chain_sr   = 24'hFFFFFF;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc_ctr = 0;
  int last_stb = -1;

  logic [23:0] prev_m, last_word;
  logic [15:0] e1, e2;

  always #5 clk = ~clk;
  always @(posedge clk) cyc_ctr <= cyc_ctr + 1;

  snac_db15_reader #(.CLK_DIV(2), .NBITS(24), .GAP_TICKS(4)) dut (
    .clk_sys(clk), .reset(rst), .enable(en), .JOY_DATA(joy_data),
    .JOY_CLK(joy_clk), .JOY_LOAD(joy_load),
    .joystick1(j1), .joystick2(j2), .frame_stb(stb)
  );

  snac_db15_reader dut_d (
    .clk_sys(clk), .reset(rst), .enable(en), .JOY_DATA(d_data),
    .JOY_CLK(d_clk), .JOY_LOAD(d_load),
    .joystick1(d_j1), .joystick2(d_j2), .frame_stb(d_stb)
  );

  // Parallel load while JOY_LOAD is low, shift toward the output on each JOY_CLK rising edge.
  always @(posedge joy_clk or negedge joy_load) begin
    if (!joy_load) chain_sr <= chain_word;
    else           chain_sr <= {1'b1, chain_sr[23:1]};
  end
  assign joy_data = chain_sr[0];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic timeout(input string nm);
    n_cmp++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT event", nm);
  endtask

  task automatic wait_load_low();
    int n = 0;
    while (joy_load !== 1'b0 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (joy_load !== 1'b0) timeout("wait_load_low");
  endtask

  // One full frame with the chain presenting 'word'; checks frame shape and model-predicted outputs.
  task automatic run_frame(input logic [23:0] word);
    int rises = 0, lowc = 0, n = 0;
    logic last_clk;
    logic [23:0] frame;
    bit got = 0;
    chain_word = word;
    last_clk = joy_clk;
    while (!got && n < 4000) begin
      @(negedge clk);
      n++;
      if (joy_clk === 1'b1 && last_clk === 1'b0) rises++;
      last_clk = joy_clk;
      if (joy_load === 1'b0) lowc++;
      if (stb === 1'b1) got = 1;
    end
    if (!got) begin
      timeout("frame_stb");
      return;
    end
    check("clk_rises", rises, 24);
    check("load_low_cycles", lowc, 4);
    if (last_stb >= 0) check("frame_period", cyc_ctr - last_stb, 109);
    last_stb = cyc_ctr;
    frame = ~word;
    if (frame == prev_m) begin
      e1 = 16'(frame[11:0]);
      e2 = 16'(frame[23:12]);
    end
    prev_m = frame;
    @(negedge clk);
    check("stb_one_cycle", stb, 0);
    check("joystick1", j1, e1);
    check("joystick2", j2, e2);
    last_word = word;
  endtask

  typedef struct {
    logic [23:0] word;
    logic [15:0] x1;
    logic [15:0] x2;
  } vec_t;
  vec_t tbl[12];

  initial begin
    int rises, lowc, stbs, lo, hi, n;
    logic last_clk;

    tbl[0]  = '{24'hFFFFFE, 16'h0000, 16'h0000};
    tbl[1]  = '{24'hFFFFFE, 16'h0001, 16'h0000};
    tbl[2]  = '{24'h7FF7FF, 16'h0001, 16'h0000};
    tbl[3]  = '{24'h7FF7FF, 16'h0800, 16'h0800};
    tbl[4]  = '{24'hFFFFFF, 16'h0800, 16'h0800};
    tbl[5]  = '{24'h7FF7FF, 16'h0800, 16'h0800};
    tbl[6]  = '{24'hFFFFFF, 16'h0800, 16'h0800};
    tbl[7]  = '{24'h7FF7FF, 16'h0800, 16'h0800};
    tbl[8]  = '{24'h000000, 16'h0800, 16'h0800};
    tbl[9]  = '{24'h000000, 16'h0FFF, 16'h0FFF};
    tbl[10] = '{24'hAAA555, 16'h0800, 16'h0800};
    tbl[11] = '{24'hAAA555, 16'h0AAA, 16'h0555};
    tbl[10].x1 = 16'h0FFF;
    tbl[10].x2 = 16'h0FFF;

    rst = 1'b1;
    en  = 1'b1;
    prev_m = '0;
    e1 = '0;
    e2 = '0;
    last_word = 24'hFFFFFF;
    repeat (5) @(negedge clk);
    check("rst_joy_clk", joy_clk, 1);
    check("rst_joy_load", joy_load, 1);
    check("rst_j1", j1, 0);
    check("rst_j2", j2, 0);
    check("rst_stb", stb, 0);
    check("rst_default_clk", d_clk, 1);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      run_frame(tbl[i].word);
      check("tbl_j1", j1, tbl[i].x1);
      check("tbl_j2", j2, tbl[i].x2);
    end

    for (int i = 0; i < 30; i++) begin
      if ($urandom_range(0, 1) == 1) run_frame(last_word);
      else run_frame(24'($urandom()));
    end

    // enable drops mid-shift: frame completes and updates, then outputs clear and the chain goes quiet
    chain_word = last_word;
    wait_load_low();
    repeat (20) @(negedge clk);
    en = 1'b0;
    n = 0;
    while (stb !== 1'b1 && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (stb !== 1'b1) timeout("stb_after_disable");
    if (~last_word == prev_m) begin
      e1 = 16'(prev_m[11:0]);
      e2 = 16'(prev_m[23:12]);
    end
    @(negedge clk);
    check("dis_done_j1", j1, e1);
    check("dis_done_j2", j2, e2);
    repeat (3) @(negedge clk);
    check("dis_clear_j1", j1, 0);
    check("dis_clear_j2", j2, 0);
    rises = 0;
    lowc = 0;
    stbs = 0;
    last_clk = joy_clk;
    repeat (300) begin
      @(negedge clk);
      if (joy_clk === 1'b1 && last_clk === 1'b0) rises++;
      last_clk = joy_clk;
      if (joy_load !== 1'b1) lowc++;
      if (stb !== 1'b0) stbs++;
    end
    check("dis_no_clk_edges", rises, 0);
    check("dis_load_idle", lowc, 0);
    check("dis_no_stb", stbs, 0);
    prev_m = '0;
    e1 = '0;
    e2 = '0;
    last_stb = -1;
    en = 1'b1;
    run_frame(24'hFFFFFE);
    run_frame(24'hFFFFFE);

    // reset mid-shift: idle outputs next cycle, then two matching frames needed again
    chain_word = 24'h7FF7FF;
    wait_load_low();
    repeat (30) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_clk", joy_clk, 1);
    check("mid_rst_load", joy_load, 1);
    check("mid_rst_j1", j1, 0);
    check("mid_rst_j2", j2, 0);
    check("mid_rst_stb", stb, 0);
    rst = 1'b0;
    prev_m = '0;
    e1 = '0;
    e2 = '0;
    last_stb = -1;
    run_frame(24'h7FF7FF);
    check("post_rst_first_j1", j1, 0);
    run_frame(24'h7FF7FF);
    check("post_rst_second_j1", j1, 16'h0800);
    check("post_rst_second_j2", j2, 16'h0800);

    // default divider: half-periods of JOY_CLK on the default instance
    n = 0;
    while (d_load !== 1'b0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (d_load !== 1'b0) timeout("default_load");
    n = 0;
    while (d_clk !== 1'b0 && n < 6000) begin
      @(negedge clk);
      n++;
    end
    if (d_clk !== 1'b0) timeout("default_clk_fall");
    lo = 0;
    while (d_clk === 1'b0 && lo < 100) begin
      @(negedge clk);
      lo++;
    end
    hi = 0;
    while (d_clk === 1'b1 && hi < 100) begin
      @(negedge clk);
      hi++;
    end
    check("default_low_phase", lo, 24);
    check("default_high_phase", hi, 24);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
